irq_seq: RTL and testbench
==========================

# irq_seq

Parametrised interrupt sequencer sitting beside the multicycle control unit, replacing its single-wire interrupt request with NUM_IRQ maskable channels. Each channel is individually level- or edge-sensitive. The block owns the SR/Cause/EPC state and arbitrates by fixed priority. It raises one request to the control FSM, latches EPC and cause on acknowledge, and clears EXL on eret.

## Interface
Parameters:
- NUM_IRQ, 6: interrupt channels, legal 1..16.
- PC_W, 32: EPC/PC width.
- EDGE_MASK, 0: NUM_IRQ-bit mask. Bit i = 1 makes channel i rising-edge sensitive; 0 makes it level sensitive.
- ISR_ADDR, 32'h0000_4180: handler entry address.

Ports:
- clk_I  in  1  single clock, rising edge.
- rstn_I  in  1  reset, asynchronous, active-low.
- irq_I  in  NUM_IRQ  interrupt lines, synchronous to clk_I.
- ack_I  in  1  control FSM is in its interrupt-entry state (one-cycle pulse).
- pc_I  in  PC_W  return address presented with ack_I.
- eret_I  in  1  control FSM is in its eret state (one-cycle pulse).
- cp0_we_I  in  1  mtc0 write strobe.
- cp0_sel_I  in  2  register select: 0 SR, 1 Cause, 2 EPC.
- cp0_wdata_I  in  32  mtc0 data.
- cp0_rdata_O  out  32  mfc0 data, combinational on cp0_sel_I.
- intreq_O  out  1  request to control FSM.
- isr_pc_O  out  PC_W  constant ISR_ADDR.
- epc_O  out  PC_W  EPC register.
- exl_O  out  1  exception level.

## Operation
- Register layout:
  - SR: bit0 IE, bit1 EXL, bits[10 +: NUM_IRQ] IM.
  - Cause: bits[10 +: NUM_IRQ] IP (pending), bits[6:2] ExcCode = winning channel index.
  - Unused bits read 0.
- Pending bits:
  - Level channel: IP[i] = registered irq_I[i].
  - Edge channel: IP[i] set on irq_I & ~prev_irq. It is cleared by ack_I of that channel, or by a Cause write with bit 10+i = 1 (write-1-to-clear). Set wins over a same-cycle clear.
- Arbitration: pending & IM. The lowest index wins; the winner is selected combinationally.
- FSM states:
  - IDLE → REQ when IE & ~EXL & |(IP & IM).
  - REQ (intreq_O = 1) → SVC on ack_I. On that edge: EPC ← pc_I, EXL ← 1, ExcCode ← winner, edge IP[winner] cleared.
  - REQ → IDLE if the request condition drops before ack_I (line withdrawn, mask or IE cleared).
  - SVC → IDLE on eret_I, which clears EXL.
  - EXL blocks any further request; no nesting.
- An ack_I outside REQ is ignored, with no state change. An eret_I outside SVC only clears EXL.
- mtc0:
  - SR writes update IE, IM and EXL.
  - EPC writes update EPC.
  - Cause writes only clear edge IP bits.
- Simultaneous events:
  - ack_I together with an mtc0 to SR or EPC: ack wins; the mtc0 is dropped.
  - eret_I together with an SR write: SR write value applies, then EXL is forced 0.
- Reset (any time, including mid-REQ or in SVC): state IDLE; SR, Cause, EPC and prev_irq all 0. Outputs after reset: intreq_O = 0, epc_O = 0, exl_O = 0, cp0_rdata_O is SR = 0 (sel 0), isr_pc_O = ISR_ADDR.

## Timing
- Latency from irq_I to intreq_O is 2 cycles:
  - irq_I high in cycle n.
  - IP is set at the end of n.
  - The FSM enters REQ at the end of n+1.
  - intreq_O is high in n+2.
- intreq_O is a registered state decode (glitch-free). It holds until ack_I or withdrawal.
- Effects of ack_I, eret_I and mtc0 are visible on the next cycle.
- cp0_rdata_O is same-cycle and reflects register values before that edge's updates.
- A new request is possible 1 cycle after eret, provided pending & IM & IE.

## Structure
- Shared package cp0_pkg holds:
  - CP0_SEL_SR, CP0_SEL_CAUSE, CP0_SEL_EPC;
  - SR/Cause bit-position constants (IE_BIT, EXL_BIT, IM_LSB, IP_LSB, EXC_LSB);
  - the state enum IRQ_IDLE/IRQ_REQ/IRQ_SVC.
- One sub-module, irq_prio_enc (parametrised NUM_IRQ): takes a request vector; outputs a valid flag and a 5-bit index.

## Test plan
- Reset: rstn_I low mid-REQ → intreq_O = 0, epc_O = 0, exl_O = 0 asynchronously. After release, irq_I = 0 keeps state IDLE.
- Level request: SR = 0x0000_FC01, irq_I[3] high at cycle n → intreq_O high at n+2. ack_I with pc_I = 0x3010 → epc_O = 0x3010, exl_O = 1, Cause[6:2] = 3, intreq_O = 0.
- Priority and masking: irq_I = 6'b101000 with IM[3] = 0 → ExcCode = 5. Repeat with IM all ones → ExcCode = 3.
- Edge channel (EDGE_MASK = 6'b000001): a one-cycle pulse on irq_I[0] keeps IP[0] = 1 after the line drops. ack_I clears it; a Cause write of 0x400 also clears it.
- Withdrawal: in REQ, write SR IE = 0 → intreq_O low next cycle, state IDLE, EPC unchanged.
- eret and collision: in SVC with irq_I[1] still high, pulse eret_I → exl_O = 0, intreq_O high 1 cycle later. ack_I together with an EPC write of 0xDEAD → epc_O = pc_I.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions for the interrupt sequencer: register selects,
// SR/Cause bit positions and the sequencer state type.
package cp0_pkg;

    localparam logic [1:0] CP0_SEL_SR    = 2'd0;
    localparam logic [1:0] CP0_SEL_CAUSE = 2'd1;
    localparam logic [1:0] CP0_SEL_EPC   = 2'd2;

    localparam int IE_BIT  = 0;
    localparam int EXL_BIT = 1;
    localparam int IM_LSB  = 10;
    localparam int IP_LSB  = 10;
    localparam int EXC_LSB = 2;
    localparam int EXC_W   = 5;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_REQ,
        IRQ_SVC
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set request bit wins.
module irq_prio_enc #(
    parameter int NUM_IRQ = 6
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic               valid_o,
    output logic [4:0]         idx_o
);

    // Scan from the top down so the lowest set bit is written last and wins
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = 5'(i);
            end
        end
    end

endmodule

// File: rtl/irq_seq.sv
// Interrupt sequencer: owns SR/Cause/EPC, tracks level/edge pending bits,
// arbitrates by fixed priority and hands one request to the control FSM.
module irq_seq
    import cp0_pkg::*;
#(
    parameter int                NUM_IRQ   = 6,
    parameter int                PC_W      = 32,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0,
    parameter logic [PC_W-1:0]   ISR_ADDR  = PC_W'(32'h0000_4180)
) (
    input  logic               clk_I,
    input  logic               rstn_I,
    input  logic [NUM_IRQ-1:0] irq_I,
    input  logic               ack_I,
    input  logic [PC_W-1:0]    pc_I,
    input  logic               eret_I,
    input  logic               cp0_we_I,
    input  logic [1:0]         cp0_sel_I,
    input  logic [31:0]        cp0_wdata_I,
    output logic [31:0]        cp0_rdata_O,
    output logic               intreq_O,
    output logic [PC_W-1:0]    isr_pc_O,
    output logic [PC_W-1:0]    epc_O,
    output logic               exl_O
);

    irq_state_e         state_q;
    logic               intreq_q;
    logic [NUM_IRQ-1:0] prevIrq_q;
    logic [NUM_IRQ-1:0] ip_q, ip_d;
    logic [NUM_IRQ-1:0] im_q, im_d;
    logic               ie_q, ie_d;
    logic               exl_q, exl_d;
    logic [EXC_W-1:0]   exc_q, exc_d;
    logic [PC_W-1:0]    epc_q, epc_d;

    logic [NUM_IRQ-1:0] pendMasked;
    logic               winValid;
    logic [4:0]         winIdx;
    logic [NUM_IRQ-1:0] winOneHot;
    logic [NUM_IRQ-1:0] ipRise;
    logic [NUM_IRQ-1:0] ipClear;
    logic               ackTake;
    logic               srWr, causeWr, epcWr;
    logic               reqNow, reqNext;
    logic [31:0]        srVal, causeVal;
    logic               wdata_unused;

    assign pendMasked = ip_q & im_q;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio (
        .req_i   (pendMasked),
        .valid_o (winValid),
        .idx_o   (winIdx)
    );

    assign ackTake   = ack_I && (state_q == IRQ_REQ);
    assign srWr      = cp0_we_I && (cp0_sel_I == CP0_SEL_SR);
    assign causeWr   = cp0_we_I && (cp0_sel_I == CP0_SEL_CAUSE);
    assign epcWr     = cp0_we_I && (cp0_sel_I == CP0_SEL_EPC);
    assign winOneHot = winValid ? (NUM_IRQ'(1) << winIdx) : '0;
    assign wdata_unused = ^cp0_wdata_I;

    // Next values of the architectural CP0 state; an accepted ack overrides mtc0
    always_comb begin
        ipRise  = irq_I & ~prevIrq_q;
        ipClear = '0;
        if (causeWr) begin
            ipClear = ipClear | cp0_wdata_I[IP_LSB +: NUM_IRQ];
        end
        if (ackTake) begin
            ipClear = ipClear | winOneHot;
        end
        ip_d  = (EDGE_MASK & ((ip_q & ~ipClear) | ipRise)) | (~EDGE_MASK & irq_I);
        ie_d  = ie_q;
        im_d  = im_q;
        exl_d = exl_q;
        exc_d = exc_q;
        epc_d = epc_q;
        if (ackTake) begin
            epc_d = pc_I;
            exl_d = 1'b1;
            exc_d = winIdx;
        end else begin
            if (srWr) begin
                ie_d  = cp0_wdata_I[IE_BIT];
                exl_d = cp0_wdata_I[EXL_BIT];
                im_d  = cp0_wdata_I[IM_LSB +: NUM_IRQ];
            end
            if (epcWr) begin
                epc_d = PC_W'(cp0_wdata_I);
            end
        end
        if (eret_I && !ackTake) begin
            exl_d = 1'b0;
        end
        reqNow  = ie_q && !exl_q && (|(ip_q & im_q));
        reqNext = ie_d && !exl_d && (|(ip_d & im_d));
    end

    // Register all CP0 state and run the IDLE/REQ/SVC sequencer with a registered request
    always_ff @(posedge clk_I or negedge rstn_I) begin
        if (!rstn_I) begin
            state_q   <= IRQ_IDLE;
            intreq_q  <= 1'b0;
            prevIrq_q <= '0;
            ip_q      <= '0;
            im_q      <= '0;
            ie_q      <= 1'b0;
            exl_q     <= 1'b0;
            exc_q     <= '0;
            epc_q     <= '0;
        end else begin
            prevIrq_q <= irq_I;
            ip_q      <= ip_d;
            im_q      <= im_d;
            ie_q      <= ie_d;
            exl_q     <= exl_d;
            exc_q     <= exc_d;
            epc_q     <= epc_d;
            case (state_q)
                IRQ_IDLE: begin
                    if (reqNow) begin
                        state_q  <= IRQ_REQ;
                        intreq_q <= 1'b1;
                    end
                end
                IRQ_REQ: begin
                    if (ackTake) begin
                        state_q  <= IRQ_SVC;
                        intreq_q <= 1'b0;
                    end else if (!reqNext) begin
                        state_q  <= IRQ_IDLE;
                        intreq_q <= 1'b0;
                    end
                end
                IRQ_SVC: begin
                    if (eret_I) begin
                        state_q <= IRQ_IDLE;
                    end
                end
                default: begin
                    state_q  <= IRQ_IDLE;
                    intreq_q <= 1'b0;
                end
            endcase
        end
    end

    // mfc0 read path shows the register values held before this edge
    always_comb begin
        srVal                      = '0;
        srVal[IE_BIT]              = ie_q;
        srVal[EXL_BIT]             = exl_q;
        srVal[IM_LSB +: NUM_IRQ]   = im_q;
        causeVal                   = '0;
        causeVal[IP_LSB +: NUM_IRQ] = ip_q;
        causeVal[EXC_LSB +: EXC_W] = exc_q;
        case (cp0_sel_I)
            CP0_SEL_SR:    cp0_rdata_O = srVal;
            CP0_SEL_CAUSE: cp0_rdata_O = causeVal;
            CP0_SEL_EPC:   cp0_rdata_O = 32'(epc_q);
            default:       cp0_rdata_O = '0;
        endcase
    end

    assign intreq_O = intreq_q;
    assign isr_pc_O = ISR_ADDR;
    assign epc_O    = epc_q;
    assign exl_O    = exl_q;

endmodule

// File: tb/tb_irq_seq.sv
// Testbench for irq_seq: directed scenarios followed by random traffic,
// every cycle compared against an architectural reference model.
module tb_irq_seq;

    localparam int          N    = 6;
    localparam logic [5:0]  EDGE = 6'b000001;
    localparam logic [31:0] ISR  = 32'h0000_4180;
    localparam int MODE_IDLE = 0;
    localparam int MODE_REQ  = 1;
    localparam int MODE_SVC  = 2;

    logic        clk_I = 1'b0;
    logic        rstn_I = 1'b0;
    logic [5:0]  irq_I = '0;
    logic        ack_I = 1'b0;
    logic [31:0] pc_I = '0;
    logic        eret_I = 1'b0;
    logic        cp0_we_I = 1'b0;
    logic [1:0]  cp0_sel_I = '0;
    logic [31:0] cp0_wdata_I = '0;
    logic [31:0] cp0_rdata_O;
    logic        intreq_O;
    logic [31:0] isr_pc_O;
    logic [31:0] epc_O;
    logic        exl_O;

    int checks = 0;
    int failures = 0;

    // Reference model: architectural registers plus the sequencer's mode
    bit          mIE, mEXL;
    logic [5:0]  mIM, mIP, mPrev;
    logic [4:0]  mExc;
    logic [31:0] mEPC;
    int          mode;

    irq_seq #(
        .NUM_IRQ   (N),
        .PC_W      (32),
        .EDGE_MASK (EDGE),
        .ISR_ADDR  (ISR)
    ) dut (
        .clk_I       (clk_I),
        .rstn_I      (rstn_I),
        .irq_I       (irq_I),
        .ack_I       (ack_I),
        .pc_I        (pc_I),
        .eret_I      (eret_I),
        .cp0_we_I    (cp0_we_I),
        .cp0_sel_I   (cp0_sel_I),
        .cp0_wdata_I (cp0_wdata_I),
        .cp0_rdata_O (cp0_rdata_O),
        .intreq_O    (intreq_O),
        .isr_pc_O    (isr_pc_O),
        .epc_O       (epc_O),
        .exl_O       (exl_O)
    );

    // Free-running 10 ns clock
    always #5 clk_I = ~clk_I;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [1:0] sel);
        case (sel)
            2'd0:    return {16'd0, mIM, 8'd0, mEXL, mIE};
            2'd1:    return {16'd0, mIP, 3'd0, mExc, 2'd0};
            2'd2:    return mEPC;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit wantsService(input bit ie, input bit exl, input logic [5:0] ip, input logic [5:0] im);
        return ie && !exl && ((ip & im) != 6'd0);
    endfunction

    task automatic modelReset();
        mIE = 0; mEXL = 0; mIM = '0; mIP = '0; mPrev = '0; mExc = '0; mEPC = '0;
        mode = MODE_IDLE;
    endtask

    // Apply one clock edge worth of architectural rules to the model
    task automatic modelUpdate();
        bit          accept;
        int          win;
        logic [5:0]  nIP;
        bit          nIE, nEXL;
        logic [5:0]  nIM;
        logic [4:0]  nExc;
        logic [31:0] nEPC;
        bit          cleared;
        accept = ack_I && (mode == MODE_REQ);
        win = -1;
        for (int i = 0; i < N; i++) begin
            if (win < 0 && mIP[i] && mIM[i]) win = i;
        end
        for (int i = 0; i < N; i++) begin
            if (EDGE[i]) begin
                cleared = (cp0_we_I && cp0_sel_I == 2'd1 && cp0_wdata_I[10 + i]) || (accept && win == i);
                nIP[i] = (irq_I[i] && !mPrev[i]) || (mIP[i] && !cleared);
            end else begin
                nIP[i] = irq_I[i];
            end
        end
        nIE = mIE; nEXL = mEXL; nIM = mIM; nExc = mExc; nEPC = mEPC;
        if (accept) begin
            nEPC = pc_I;
            nEXL = 1;
            nExc = (win < 0) ? 5'd0 : 5'(win);
        end else if (cp0_we_I) begin
            if (cp0_sel_I == 2'd0) begin
                nIE  = cp0_wdata_I[0];
                nEXL = cp0_wdata_I[1];
                nIM  = cp0_wdata_I[15:10];
            end else if (cp0_sel_I == 2'd2) begin
                nEPC = cp0_wdata_I;
            end
        end
        if (eret_I && !accept) nEXL = 0;
        case (mode)
            MODE_IDLE: if (wantsService(mIE, mEXL, mIP, mIM)) mode = MODE_REQ;
            MODE_REQ: begin
                if (accept) mode = MODE_SVC;
                else if (!wantsService(nIE, nEXL, nIP, nIM)) mode = MODE_IDLE;
            end
            default: if (eret_I) mode = MODE_IDLE;
        endcase
        mIP = nIP; mIE = nIE; mEXL = nEXL; mIM = nIM; mExc = nExc; mEPC = nEPC;
        mPrev = irq_I;
    endtask

    // One cycle: check the combinational read, clock, check registered outputs
    task automatic applyStimulus();
        #1;
        checkOutput("rdata", cp0_rdata_O, modelRead(cp0_sel_I));
        @(posedge clk_I);
        modelUpdate();
        #1;
        ack_I = 0; eret_I = 0; cp0_we_I = 0;
        checkOutput("intreq", {31'd0, intreq_O}, {31'd0, mode == MODE_REQ});
        checkOutput("epc", epc_O, mEPC);
        checkOutput("exl", {31'd0, exl_O}, {31'd0, mEXL});
    endtask

    task automatic writeCp0(input logic [1:0] sel, input logic [31:0] data);
        cp0_we_I = 1; cp0_sel_I = sel; cp0_wdata_I = data;
        applyStimulus();
    endtask

    task automatic readCheck(input string tag, input logic [1:0] sel, input logic [31:0] mask, input logic [31:0] exp);
        cp0_sel_I = sel;
        #1;
        checkOutput(tag, cp0_rdata_O & mask, exp);
    endtask

    initial begin
        modelReset();
        #2;
        checkOutput("rst_intreq", {31'd0, intreq_O}, 32'd0);
        checkOutput("rst_rdata", cp0_rdata_O, 32'd0);
        checkOutput("rst_isr", isr_pc_O, ISR);
        #10;
        rstn_I = 1;
        applyStimulus();

        // Level request on channel 3
        writeCp0(2'd0, 32'h0000_FC01);
        irq_I = 6'b001000;
        applyStimulus();
        checkOutput("lvl_n1", {31'd0, intreq_O}, 32'd0);
        applyStimulus();
        checkOutput("lvl_n2", {31'd0, intreq_O}, 32'd1);
        ack_I = 1; pc_I = 32'h3010;
        applyStimulus();
        checkOutput("lvl_epc", epc_O, 32'h3010);
        checkOutput("lvl_exl", {31'd0, exl_O}, 32'd1);
        checkOutput("lvl_req", {31'd0, intreq_O}, 32'd0);
        readCheck("lvl_exc", 2'd1, 32'h7C, 32'd3 << 2);
        irq_I = '0; eret_I = 1;
        applyStimulus();
        applyStimulus();

        // Asynchronous reset while requesting
        irq_I = 6'b001000;
        applyStimulus();
        applyStimulus();
        checkOutput("pre_rst_req", {31'd0, intreq_O}, 32'd1);
        #3;
        rstn_I = 0;
        #1;
        modelReset();
        checkOutput("arst_intreq", {31'd0, intreq_O}, 32'd0);
        checkOutput("arst_epc", epc_O, 32'd0);
        checkOutput("arst_exl", {31'd0, exl_O}, 32'd0);
        irq_I = '0; cp0_sel_I = 2'd0;
        #2;
        rstn_I = 1;
        for (int k = 0; k < 3; k++) applyStimulus();
        checkOutput("post_rst_idle", {31'd0, intreq_O}, 32'd0);

        // Priority with channel 3 masked, then SR write colliding with eret
        writeCp0(2'd0, 32'h0000_DC01);
        irq_I = 6'b101000;
        applyStimulus();
        applyStimulus();
        ack_I = 1; pc_I = 32'h100;
        applyStimulus();
        readCheck("prio_masked", 2'd1, 32'h7C, 32'd5 << 2);
        eret_I = 1; cp0_we_I = 1; cp0_sel_I = 2'd0; cp0_wdata_I = 32'h0000_FC03;
        applyStimulus();
        checkOutput("eret_sr_exl", {31'd0, exl_O}, 32'd0);
        applyStimulus();
        checkOutput("prio_req", {31'd0, intreq_O}, 32'd1);
        ack_I = 1; pc_I = 32'h104;
        applyStimulus();
        readCheck("prio_all", 2'd1, 32'h7C, 32'd3 << 2);
        irq_I = '0; eret_I = 1;
        applyStimulus();
        applyStimulus();

        // Edge channel 0: pulse is remembered, cleared by ack
        irq_I = 6'b000001;
        applyStimulus();
        irq_I = '0;
        applyStimulus();
        readCheck("edge_held", 2'd1, 32'h400, 32'h400);
        checkOutput("edge_req", {31'd0, intreq_O}, 32'd1);
        ack_I = 1; pc_I = 32'h200;
        applyStimulus();
        readCheck("edge_ack_clr", 2'd1, 32'h47C, 32'h0);
        eret_I = 1;
        applyStimulus();
        // Edge channel 0: cleared by write-1-to-clear on Cause
        writeCp0(2'd0, 32'h0000_FC00);
        irq_I = 6'b000001;
        applyStimulus();
        irq_I = '0;
        applyStimulus();
        readCheck("edge_held2", 2'd1, 32'h400, 32'h400);
        writeCp0(2'd1, 32'h0000_0400);
        readCheck("edge_w1c", 2'd1, 32'h400, 32'h0);

        // Withdrawal by clearing IE while requesting
        writeCp0(2'd0, 32'h0000_FC01);
        irq_I = 6'b000100;
        applyStimulus();
        applyStimulus();
        checkOutput("wd_req", {31'd0, intreq_O}, 32'd1);
        writeCp0(2'd0, 32'h0000_FC00);
        checkOutput("wd_drop", {31'd0, intreq_O}, 32'd0);
        checkOutput("wd_epc", epc_O, 32'h200);
        ack_I = 1; pc_I = 32'h999;
        applyStimulus();
        checkOutput("stray_ack", {31'd0, exl_O}, 32'd0);

        // ack beats a same-cycle EPC write; eret re-opens requests next cycle
        irq_I = 6'b000010;
        writeCp0(2'd0, 32'h0000_FC01);
        applyStimulus();
        ack_I = 1; pc_I = 32'h2000;
        cp0_we_I = 1; cp0_sel_I = 2'd2; cp0_wdata_I = 32'hDEAD;
        applyStimulus();
        checkOutput("ack_vs_epc", epc_O, 32'h2000);
        eret_I = 1;
        applyStimulus();
        checkOutput("eret_exl", {31'd0, exl_O}, 32'd0);
        applyStimulus();
        checkOutput("eret_rereq", {31'd0, intreq_O}, 32'd1);

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            irq_I     = 6'($urandom);
            cp0_sel_I = 2'($urandom_range(0, 3));
            pc_I      = $urandom;
            ack_I     = ($urandom_range(0, 3) == 0);
            eret_I    = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) begin
                cp0_we_I    = 1;
                cp0_sel_I   = 2'($urandom_range(0, 2));
                cp0_wdata_I = $urandom;
                if (cp0_sel_I == 2'd0) begin
                    cp0_wdata_I[0] = ($urandom_range(0, 3) != 0);
                    cp0_wdata_I[1] = ($urandom_range(0, 3) == 0);
                end
            end
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
